// File: rtl/smp_bus_arbiter.sv
// smp_bus_arbiter
// Round-robin arbiter and transaction sequencer for the shared snoop bus.
// Grants one core at a time, broadcasts the latched address, strobes
// invalidates to non-owners on writes, runs the memory access and returns
// a one-cycle done pulse to the owner.
// Optional feature: define SMP_ARB_TIMEOUT_EN to bound the memory wait by
// TIMEOUT cycles and report expiry through err. Without it MEM waits
// indefinitely and err stays 0.

module smp_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        req_rw,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        done,
    output logic [NUM_CORES-1:0]        err,
    output logic                        busy,
    output logic [ADDR_W-1:0]           snoop_addr,
    output logic [NUM_CORES-1:0]        snoop_inv,
    output logic                        mem_req,
    output logic                        mem_rw,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_MEM   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       r_owner;
    logic [NUM_CORES-1:0]   r_gnt;
    logic [NUM_CORES-1:0]   r_done;
    logic [NUM_CORES-1:0]   r_err;
    logic                   r_busy;
    logic [ADDR_W-1:0]      r_snoop_addr;
    logic [NUM_CORES-1:0]   r_snoop_inv;
    logic                   r_mem_req;
    logic                   r_mem_rw;
    logic [ADDR_W-1:0]      r_mem_addr;

`ifdef SMP_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]       r_cnt;
`endif

    logic                   w_any;
    logic [IDX_W-1:0]       w_win_idx;
    logic [NUM_CORES-1:0]   w_win_oh;
    logic [ADDR_W-1:0]      w_win_addr;
    logic                   w_win_rw;

    // Round-robin winner: scan from last_winner+1 with wrap; the scan runs
    // farthest-first so the nearest requester is the final assignment.
    always_comb begin
        logic [IDX_W-1:0] cand;
        w_any     = |req;
        w_win_idx = {IDX_W{1'b0}};
        cand      = {IDX_W{1'b0}};
        for (int i = NUM_CORES; i >= 1; i--) begin
            cand = IDX_W'((int'(r_last) + i) % NUM_CORES);
            if (req[cand]) begin
                w_win_idx = cand;
            end else begin
                w_win_idx = w_win_idx;
            end
        end
        w_win_oh   = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_win_idx;
        w_win_addr = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
        w_win_rw   = req_rw[w_win_idx];
    end

    // Transaction FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last       <= IDX_W'(NUM_CORES - 1);
            r_owner      <= {IDX_W{1'b0}};
            r_gnt        <= {NUM_CORES{1'b0}};
            r_done       <= {NUM_CORES{1'b0}};
            r_err        <= {NUM_CORES{1'b0}};
            r_busy       <= 1'b0;
            r_snoop_addr <= {ADDR_W{1'b0}};
            r_snoop_inv  <= {NUM_CORES{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
`ifdef SMP_ARB_TIMEOUT_EN
            r_cnt        <= {CNT_W{1'b0}};
`endif
        end else begin
            r_done      <= {NUM_CORES{1'b0}};
            r_err       <= {NUM_CORES{1'b0}};
            r_snoop_inv <= {NUM_CORES{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state      <= ST_SNOOP;
                        r_owner      <= w_win_idx;
                        r_gnt        <= w_win_oh;
                        r_busy       <= 1'b1;
                        r_mem_rw     <= w_win_rw;
                        r_mem_addr   <= w_win_addr;
                        r_snoop_addr <= w_win_addr;
                        // invalidate strobe is visible exactly while in SNOOP
                        r_snoop_inv  <= w_win_rw ? ~w_win_oh : {NUM_CORES{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SNOOP: begin
                    r_state   <= ST_MEM;
                    r_mem_req <= 1'b1;
`ifdef SMP_ARB_TIMEOUT_EN
                    r_cnt     <= {CNT_W{1'b0}};
`endif
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= r_gnt;
                    end
`ifdef SMP_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= r_gnt;
                        r_err     <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`else
                    else begin
                        r_state <= ST_MEM;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= {NUM_CORES{1'b0}};
                    r_busy  <= 1'b0;
                    r_last  <= r_owner;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= {NUM_CORES{1'b0}};
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;
    assign snoop_addr = r_snoop_addr;
    assign snoop_inv  = r_snoop_inv;
    assign mem_req    = r_mem_req;
    assign mem_rw     = r_mem_rw;
    assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_smp_bus_arbiter.sv
// Directed self-checking bench for smp_bus_arbiter (4 cores, 32-bit address,
// TIMEOUT=8 so the optional timeout build finishes quickly).

module tb_smp_bus_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_rw;
    logic [127:0] req_addr;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [3:0]   err;
    logic         busy;
    logic [31:0]  snoop_addr;
    logic [3:0]   snoop_inv;
    logic         mem_req;
    logic         mem_rw;
    logic [31:0]  mem_addr;
    logic         mem_ack;

    int tests_run;
    int tests_failed;

    smp_bus_arbiter #(.NUM_CORES(4), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .snoop_addr(snoop_addr),
        .snoop_inv(snoop_inv), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0; req_rw = 4'b0; req_addr = 128'h0; mem_ack = 1'b0;
        tick(); tick();
        tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests_run++; if ({busy, mem_req, mem_rw, done, err, snoop_inv} !== 15'b0) begin tests_failed++; $display("FAIL reset_ctrl: got busy=%b mem_req=%b mem_rw=%b done=%b err=%b inv=%b want all 0", busy, mem_req, mem_rw, done, err, snoop_inv); end
        tests_run++; if ({mem_addr, snoop_addr} !== 64'h0) begin tests_failed++; $display("FAIL reset_addr: got mem_addr=%h snoop_addr=%h want 0", mem_addr, snoop_addr); end
        reset = 1'b0;
    endtask

    task automatic test_read();
        req = 4'b0001; req_rw = 4'b0000; req_addr[31:0] = 32'h0000_0100;
        tick(); // arbitration edge
        tests_run++; if (gnt !== 4'b0001 || busy !== 1'b1) begin tests_failed++; $display("FAIL read_gnt: got gnt=%b busy=%b want 0001/1", gnt, busy); end
        tests_run++; if (snoop_inv !== 4'b0000) begin tests_failed++; $display("FAIL read_inv: got %b want 0000", snoop_inv); end
        tests_run++; if (mem_addr !== 32'h100 || snoop_addr !== 32'h100 || mem_rw !== 1'b0) begin tests_failed++; $display("FAIL read_latch: got mem_addr=%h snoop_addr=%h rw=%b want 100/100/0", mem_addr, snoop_addr, mem_rw); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL read_mreq_early: got %b want 0", mem_req); end
        tick(); // SNOOP -> MEM
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL read_mreq: got %b want 1", mem_req); end
        tick(); // memory observes request, answers next cycle
        mem_ack = 1'b1;
        tick(); // ack sampled
        mem_ack = 1'b0;
        tests_run++; if (done !== 4'b0001 || err !== 4'b0000) begin tests_failed++; $display("FAIL read_done: got done=%b err=%b want 0001/0000", done, err); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL read_mreq_drop: got %b want 0", mem_req); end
        req = 4'b0000;
        tick(); // DONE -> IDLE
        tests_run++; if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL read_idle: got done=%b gnt=%b busy=%b want 0/0/0", done, gnt, busy); end
    endtask

    task automatic test_write();
        req = 4'b0100; req_rw = 4'b0100; req_addr[95:64] = 32'h0000_00A0;
        tick();
        tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL write_gnt: got %b want 0100", gnt); end
        tests_run++; if (snoop_inv !== 4'b1011) begin tests_failed++; $display("FAIL write_inv: got %b want 1011", snoop_inv); end
        tests_run++; if (mem_rw !== 1'b1 || mem_addr !== 32'hA0) begin tests_failed++; $display("FAIL write_latch: got rw=%b addr=%h want 1/a0", mem_rw, mem_addr); end
        mem_ack = 1'b1; // ack during SNOOP must be ignored
        tick();
        mem_ack = 1'b0;
        tests_run++; if (snoop_inv !== 4'b0000 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL write_inv_once: got inv=%b mem_req=%b want 0000/1", snoop_inv, mem_req); end
        tick();
        tests_run++; if (done !== 4'b0000 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL write_stray_ack: got done=%b mem_req=%b want 0000/1", done, mem_req); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests_run++; if (done !== 4'b0100) begin tests_failed++; $display("FAIL write_done: got %b want 0100", done); end
        req = 4'b0000; req_rw = 4'b0000;
        tick();
    endtask

    task automatic test_ignore_changes();
        req = 4'b0010; req_rw = 4'b0000; req_addr[63:32] = 32'h1234_5678;
        tick();
        tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL hold_gnt: got %b want 0010", gnt); end
        tick(); // in MEM
        req = 4'b0000; req_rw = 4'b0010; req_addr[63:32] = 32'hDEAD_BEEF;
        tick();
        tests_run++; if (mem_addr !== 32'h1234_5678 || mem_rw !== 1'b0 || gnt !== 4'b0010) begin tests_failed++; $display("FAIL hold_latch: got addr=%h rw=%b gnt=%b want 12345678/0/0010", mem_addr, mem_rw, gnt); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests_run++; if (done !== 4'b0010) begin tests_failed++; $display("FAIL hold_done: got %b want 0010", done); end
        tick(); tick();
        tests_run++; if (gnt !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL hold_idle: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        req_rw = 4'b0000;
    endtask

    task automatic test_reset_mid();
        req = 4'b0001; req_rw = 4'b0001; req_addr[31:0] = 32'h0000_0200;
        tick(); tick(); // now in MEM
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rmid_setup: got mem_req=%b want 1", mem_req); end
        reset = 1'b1; mem_ack = 1'b1;
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        tests_run++; if ({gnt, done, err, busy, snoop_inv, mem_req, mem_rw} !== 19'b0) begin tests_failed++; $display("FAIL rmid_ctrl: got gnt=%b done=%b err=%b busy=%b inv=%b mreq=%b rw=%b want all 0", gnt, done, err, busy, snoop_inv, mem_req, mem_rw); end
        tests_run++; if ({mem_addr, snoop_addr} !== 64'h0) begin tests_failed++; $display("FAIL rmid_addr: got mem_addr=%h snoop_addr=%h want 0", mem_addr, snoop_addr); end
        req = 4'b1111; req_rw = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [3:0] seen;
        seen = 4'b0000;
        for (int t = 0; t < 5; t++) begin
            exp_gnt = 4'b0001 << (t % 4);
            tick(); // arbitration
            tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL rr_gnt%0d: got %b want %b", t, gnt, exp_gnt); end
            tick(); tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tests_run++; if (done !== exp_gnt) begin tests_failed++; $display("FAIL rr_done%0d: got %b want %b", t, done, exp_gnt); end
            if (t < 4) seen = seen | done;
            if (t == 4) req = 4'b0000;
            tick(); // back to IDLE
            tests_run++; if (gnt !== 4'b0000 || done !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle%0d: got gnt=%b done=%b want 0000/0000", t, gnt, done); end
        end
        tests_run++; if (seen !== 4'b1111) begin tests_failed++; $display("FAIL rr_round: got %b want 1111", seen); end
        tick();
    endtask

`ifdef SMP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        // v=0: no ack ever; v=1: ack on the same edge as the timeout
        for (int v = 0; v < 2; v++) begin
            req = 4'b1000; req_rw = 4'b0000;
            tick(); tick(); // in MEM
            for (int c = 0; c < 7; c++) begin
                tick();
                tests_run++; if (done !== 4'b0000 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL to_wait%0d_%0d: got done=%b mem_req=%b want 0000/1", v, c, done, mem_req); end
            end
            mem_ack = (v == 1);
            tick();
            mem_ack = 1'b0;
            tests_run++; if (done !== 4'b1000) begin tests_failed++; $display("FAIL to_done%0d: got %b want 1000", v, done); end
            tests_run++; if (err !== ((v == 0) ? 4'b1000 : 4'b0000)) begin tests_failed++; $display("FAIL to_err%0d: got %b want %b", v, err, (v == 0) ? 4'b1000 : 4'b0000); end
            req = 4'b0000;
            tick();
            tests_run++; if (mem_req !== 1'b0 || err !== 4'b0000 || gnt !== 4'b0000) begin tests_failed++; $display("FAIL to_after%0d: got mem_req=%b err=%b gnt=%b want 0/0000/0000", v, mem_req, err, gnt); end
        end
    endtask
`else
    task automatic test_no_timeout();
        req = 4'b1000; req_rw = 4'b0000;
        tick(); tick();
        for (int c = 0; c < 20; c++) tick();
        tests_run++; if (mem_req !== 1'b1 || done !== 4'b0000 || err !== 4'b0000) begin tests_failed++; $display("FAIL wait_forever: got mem_req=%b done=%b err=%b want 1/0000/0000", mem_req, done, err); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests_run++; if (done !== 4'b1000 || err !== 4'b0000) begin tests_failed++; $display("FAIL late_done: got done=%b err=%b want 1000/0000", done, err); end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_write();
        test_ignore_changes();
        test_reset_mid();
        test_round_robin();
`ifdef SMP_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
